// File: rtl/wfg_irq_ctrl_top.sv
// Wishbone-slave interrupt controller: edge-latched pending bits, enable mask, one registered irq line.
// Optional macro IRQ_CTRL_PRIO_EN adds a lowest-index-first priority ID register.
module wfg_irq_ctrl_top #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wbs_stb_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_we_i,
   input  logic [31:0]        wbs_dat_i,
   input  logic [31:0]        wbs_adr_i,
   output logic               wbs_ack_o,
   output logic [31:0]        wbs_dat_o,
   input  logic [NUM_IRQ-1:0] irq_src_i,
   output logic               irq_o
);

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] ADDR_SET     = 2'd2;
   localparam logic [1:0] ADDR_ID      = 2'd3;

   logic               ack_reg;
   logic               ack_next;
   logic [31:0]        dat_o_reg;
   logic [31:0]        dat_o_next;
   logic               irq_reg;
   logic               irq_next;
   logic [NUM_IRQ-1:0] src_q_reg;
   logic [NUM_IRQ-1:0] pending_reg;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] enable_reg;
   logic [NUM_IRQ-1:0] enable_next;

   logic               wr_en;
   logic               rd_en;
   logic [1:0]         reg_sel;
   logic [NUM_IRQ-1:0] wr_data;
   logic [NUM_IRQ-1:0] w1c_mask;
   logic [NUM_IRQ-1:0] set_mask;
   logic [NUM_IRQ-1:0] edge_det;
   logic [NUM_IRQ-1:0] active;
   logic [31:0]        pending_ext;
   logic [31:0]        enable_ext;
   logic [31:0]        id_value;
   logic [31:0]        rd_data;
   logic               unused_bits;

   // Only address bits [3:2] and the low NUM_IRQ data bits carry meaning.
   assign unused_bits = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

   // The access (read capture or register write) happens on the edge that raises ack.
   always_comb begin
      ack_next = wbs_stb_i & wbs_cyc_i & ~ack_reg;
      wr_en    = ack_next & wbs_we_i;
      rd_en    = ack_next & ~wbs_we_i;
      reg_sel  = wbs_adr_i[3:2];
      wr_data  = wbs_dat_i[NUM_IRQ-1:0];
   end

   always_comb begin
      w1c_mask    = '0;
      set_mask    = '0;
      enable_next = enable_reg;
      if (wr_en) begin
         case (reg_sel)
            ADDR_PENDING: w1c_mask    = wr_data;
            ADDR_ENABLE:  enable_next = wr_data;
            ADDR_SET:     set_mask    = wr_data;
            default:      ;
         endcase
      end
   end

   // Per-bit edge detect and pending update; new requests always beat a clear.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_bit
         assign edge_det[gi]     = irq_src_i[gi] & ~src_q_reg[gi];
         assign pending_next[gi] = (pending_reg[gi] & ~w1c_mask[gi]) | edge_det[gi] | set_mask[gi];
         assign active[gi]       = pending_reg[gi] & enable_reg[gi];
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_ext
         if (gi < NUM_IRQ) begin : g_live
            assign pending_ext[gi] = pending_reg[gi];
            assign enable_ext[gi]  = enable_reg[gi];
         end else begin : g_zero
            assign pending_ext[gi] = 1'b0;
            assign enable_ext[gi]  = 1'b0;
         end
      end
   endgenerate

`ifdef IRQ_CTRL_PRIO_EN
   // Scan from the top so the lowest active index is the one left standing.
   always_comb begin
      id_value = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            id_value = 32'(i + 1);
         end
      end
   end
`else
   assign id_value = '0;
`endif

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         ADDR_PENDING: rd_data = pending_ext;
         ADDR_ENABLE:  rd_data = enable_ext;
         ADDR_SET:     rd_data = '0;
         ADDR_ID:      rd_data = id_value;
         default:      rd_data = '0;
      endcase
   end

   always_comb begin
      dat_o_next = rd_en ? rd_data : 32'd0;
      irq_next   = |active;
   end

   // src_q resets high so a line already asserted at reset release is not a request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_reg     <= 1'b0;
         dat_o_reg   <= '0;
         irq_reg     <= 1'b0;
         src_q_reg   <= '1;
         pending_reg <= '0;
         enable_reg  <= '0;
      end else begin
         ack_reg     <= ack_next;
         dat_o_reg   <= dat_o_next;
         irq_reg     <= irq_next;
         src_q_reg   <= irq_src_i;
         pending_reg <= pending_next;
         enable_reg  <= enable_next;
      end
   end

   assign wbs_ack_o = ack_reg;
   assign wbs_dat_o = dat_o_reg;
   assign irq_o     = irq_reg;

endmodule
